mem_arbiter: RTL and testbench

//  Shares the single ssram_ctrl command port among three masters: video framebuffer

---
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the ssram_ctrl command port between FB, cpu and aux masters (optional stats via MEM_ARB_STATS_EN)
module mem_arbiter #(
  parameter int         STARVE_LIMIT = 8,
  parameter int         FB_MAX_OUTST = 4,
  parameter logic [1:0] ID_FB        = 2'd3,
  parameter logic [1:0] ID_AUX       = 2'd0
) (
  input  logic        clock,
  input  logic        reset_n,
`ifdef MEM_ARB_STATS_EN
  input  logic        stats_clear,
  output logic [31:0] stat_fb_grants,
  output logic [31:0] stat_cpu_grants,
  output logic [31:0] stat_aux_grants,
  output logic [31:0] stat_cpu_stall,
`endif
  input  logic        fb_read,
  input  logic [29:0] fb_address,
  output logic        fb_waitrequest,
  output logic        fb_readdatavalid,
  input  logic [1:0]  cpu_id,
  input  logic [29:0] cpu_address,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_writedata,
  input  logic [3:0]  cpu_writedatamask,
  output logic        cpu_waitrequest,
  input  logic [29:0] aux_address,
  input  logic        aux_write,
  input  logic [31:0] aux_writedata,
  input  logic [3:0]  aux_writedatamask,
  output logic        aux_waitrequest,
  output logic [1:0]  mem_id,
  output logic [29:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_writedatamask,
  input  logic        mem_waitrequest,
  input  logic [1:0]  mem_readdataid
);
  localparam int         SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] S_LIM = SW'(STARVE_LIMIT);
  localparam logic [3:0] O_MAX = 4'(FB_MAX_OUTST);
  typedef enum logic [1:0] {OWN_NONE, OWN_FB, OWN_CPU, OWN_AUX} owner_t;
  owner_t        lock_q, lock_d, owner;
  logic          rr;
  logic [3:0]    outst;
  logic [SW-1:0] starve;
  logic          cpu_req, aux_req, fb_elig, strobe, accept, fb_acc, ca_acc, fb_ret;
  // Owner selection: a held lock wins, then eligible FB, then cpu/aux round-robin
  always_comb begin
    cpu_req  = cpu_read | cpu_write;
    aux_req  = aux_write;
    fb_elig  = fb_read && (outst < O_MAX) && !(starve == S_LIM && (cpu_req || aux_req));
    owner    = !reset_n ? OWN_NONE :
               lock_q != OWN_NONE ? lock_q :
               fb_elig ? OWN_FB :
               (cpu_req && aux_req) ? (rr ? OWN_AUX : OWN_CPU) :
               cpu_req ? OWN_CPU :
               aux_req ? OWN_AUX : OWN_NONE;
    strobe   = owner == OWN_FB ? fb_read : owner == OWN_CPU ? cpu_req : owner == OWN_AUX ? aux_req : 1'b0;
    accept   = strobe && !mem_waitrequest;
    fb_acc   = accept && owner == OWN_FB;
    ca_acc   = accept && (owner == OWN_CPU || owner == OWN_AUX);
    fb_ret   = mem_readdataid == ID_FB;
    lock_d   = (strobe && mem_waitrequest) ? owner : OWN_NONE;
  end
  // Command mux towards ssram_ctrl and per-master handshakes
  always_comb begin
    mem_read          = owner == OWN_FB ? fb_read : owner == OWN_CPU ? cpu_read : 1'b0;
    mem_write         = owner == OWN_CPU ? cpu_write : owner == OWN_AUX ? aux_write : 1'b0;
    mem_id            = owner == OWN_FB ? ID_FB : owner == OWN_AUX ? ID_AUX : cpu_id;
    mem_address       = owner == OWN_FB ? fb_address : owner == OWN_AUX ? aux_address : cpu_address;
    mem_writedata     = owner == OWN_AUX ? aux_writedata : cpu_writedata;
    mem_writedatamask = owner == OWN_AUX ? aux_writedatamask : cpu_writedatamask;
    fb_waitrequest    = owner != OWN_FB || mem_waitrequest;
    cpu_waitrequest   = owner != OWN_CPU || mem_waitrequest;
    aux_waitrequest   = owner != OWN_AUX || mem_waitrequest;
    fb_readdatavalid  = fb_ret;
  end
  // Lock, round-robin pointer, starvation and FB outstanding-read tracking
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_q <= OWN_NONE;
      rr     <= 1'b0;
      starve <= '0;
      outst  <= '0;
    end else begin
      lock_q <= lock_d;
      if (ca_acc) rr <= owner == OWN_CPU;
      if (!(cpu_req || aux_req) || ca_acc) starve <= '0;
      else if (fb_acc && starve != S_LIM) starve <= starve + 1'b1;
      if (fb_acc && !fb_ret) outst <= outst + 1'b1;
      else if (!fb_acc && fb_ret && outst != 4'd0) outst <= outst - 1'b1;
    end
  end
`ifdef MEM_ARB_STATS_EN
  // Grant and cpu stall counters; a synchronous clear beats a same-cycle increment
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_fb_grants  <= '0;
      stat_cpu_grants <= '0;
      stat_aux_grants <= '0;
      stat_cpu_stall  <= '0;
    end else if (stats_clear) begin
      stat_fb_grants  <= '0;
      stat_cpu_grants <= '0;
      stat_aux_grants <= '0;
      stat_cpu_stall  <= '0;
    end else begin
      stat_fb_grants  <= stat_fb_grants + 32'(fb_acc);
      stat_cpu_grants <= stat_cpu_grants + 32'(accept && owner == OWN_CPU);
      stat_aux_grants <= stat_aux_grants + 32'(accept && owner == OWN_AUX);
      stat_cpu_stall  <= stat_cpu_stall + 32'(cpu_req && cpu_waitrequest);
    end
  end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed checks of mem_arbiter against a behavioural model
module tb_mem_arbiter;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        fb_read, fb_waitrequest, fb_readdatavalid;
  logic [29:0] fb_address, cpu_address, aux_address, mem_address;
  logic [1:0]  cpu_id, mem_id, mem_readdataid;
  logic        cpu_read, cpu_write, cpu_waitrequest, aux_write, aux_waitrequest;
  logic [31:0] cpu_writedata, aux_writedata, mem_writedata;
  logic [3:0]  cpu_writedatamask, aux_writedatamask, mem_writedatamask;
  logic        mem_read, mem_write, mem_waitrequest;
  int checks = 0, errors = 0;
  int m_outst, m_starve, m_lock, m_rr;
  int dut_fb, dut_cpu, dut_aux, dut_last;

  always #5 clock = ~clock;

  mem_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .fb_read(fb_read), .fb_address(fb_address), .fb_waitrequest(fb_waitrequest),
    .fb_readdatavalid(fb_readdatavalid),
    .cpu_id(cpu_id), .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_writedatamask(cpu_writedatamask),
    .cpu_waitrequest(cpu_waitrequest),
    .aux_address(aux_address), .aux_write(aux_write), .aux_writedata(aux_writedata),
    .aux_writedatamask(aux_writedatamask), .aux_waitrequest(aux_waitrequest),
    .mem_id(mem_id), .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_writedatamask(mem_writedatamask),
    .mem_waitrequest(mem_waitrequest), .mem_readdataid(mem_readdataid)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Who the spec says owns the port this cycle: 0 none, 1 fb, 2 cpu, 3 aux
  function automatic int pick();
    bit pending = cpu_read || cpu_write || aux_write;
    if (!reset_n) return 0;
    if (m_lock != 0) return m_lock;
    if (fb_read && m_outst < 4 && !(m_starve == 8 && pending)) return 1;
    if ((cpu_read || cpu_write) && aux_write) return m_rr ? 3 : 2;
    if (cpu_read || cpu_write) return 2;
    if (aux_write) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    m_outst = 0; m_starve = 0; m_lock = 0; m_rr = 0;
  endtask

  task automatic idle_inputs();
    fb_read = 0; cpu_read = 0; cpu_write = 0; aux_write = 0;
    mem_waitrequest = 0; mem_readdataid = 2'd0; cpu_id = 2'd1;
    fb_address = '0; cpu_address = '0; aux_address = '0;
    cpu_writedata = '0; aux_writedata = '0; cpu_writedatamask = '0; aux_writedatamask = '0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    idle_inputs();
    model_reset();
    dut_fb = 0; dut_cpu = 0; dut_aux = 0;
    repeat (2) @(negedge clock);
    reset_n = 1;
  endtask

  // One cycle: inputs already applied at the negedge; check, update model, advance to next negedge
  task automatic step();
    int who, ret;
    bit er, ew, acc, pending;
    #1;
    who = pick();
    er  = (who == 1) ? fb_read : (who == 2) ? cpu_read : 1'b0;
    ew  = (who == 2) ? cpu_write : (who == 3) ? aux_write : 1'b0;
    check("mem_read", mem_read, er);
    check("mem_write", mem_write, ew);
    check("fb_wait", fb_waitrequest, who != 1 || mem_waitrequest);
    check("cpu_wait", cpu_waitrequest, who != 2 || mem_waitrequest);
    check("aux_wait", aux_waitrequest, who != 3 || mem_waitrequest);
    check("fb_rdv", fb_readdatavalid, mem_readdataid == 2'd3);
    if (who != 0) begin
      check("mem_addr", mem_address, who == 1 ? fb_address : who == 2 ? cpu_address : aux_address);
      check("mem_id", mem_id, who == 1 ? 2'd3 : who == 2 ? cpu_id : 2'd0);
    end
    if (ew) begin
      check("mem_wdata", mem_writedata, who == 2 ? cpu_writedata : aux_writedata);
      check("mem_mask", mem_writedatamask, who == 2 ? cpu_writedatamask : aux_writedatamask);
    end
    dut_last = 0;
    if (!fb_waitrequest && fb_read) begin dut_fb++; dut_last = 1; end
    if (!cpu_waitrequest && (cpu_read || cpu_write)) begin dut_cpu++; dut_last = 2; end
    if (!aux_waitrequest && aux_write) begin dut_aux++; dut_last = 3; end
    acc     = (er || ew) && !mem_waitrequest;
    ret     = (mem_readdataid == 2'd3);
    pending = cpu_read || cpu_write || aux_write;
    if (acc && who == 1 && !ret) m_outst++;
    else if (!(acc && who == 1) && ret && m_outst > 0) m_outst--;
    if (!pending || (acc && who >= 2)) m_starve = 0;
    else if (acc && who == 1 && m_starve < 8) m_starve++;
    if (acc && who == 2) m_rr = 1;
    if (acc && who == 3) m_rr = 0;
    m_lock = ((er || ew) && mem_waitrequest) ? who : 0;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset_n = 0;
    idle_inputs();
    model_reset();
    #1;
    check("rst_read", mem_read, 1'b0);
    check("rst_write", mem_write, 1'b0);
    check("rst_waits", {fb_waitrequest, cpu_waitrequest, aux_waitrequest}, 3'b111);
    do_reset();
    // lone cpu read is granted in the same cycle
    cpu_read = 1; cpu_address = 30'h100;
    #1;
    check("t1_read", mem_read, 1'b1);
    check("t1_addr", mem_address, 30'h100);
    check("t1_wait", cpu_waitrequest, 1'b0);
    step();
    // FB and cpu contend: 8 FB grants then one cpu grant
    do_reset();
    fb_read = 1; cpu_write = 1; mem_readdataid = 2'd3;
    for (int i = 0; i < 18; i++) begin
      step();
      check("t2_seq", dut_last, (i % 9 == 8) ? 2 : 1);
    end
    check("t2_fb", dut_fb, 16);
    check("t2_cpu", dut_cpu, 2);
    // outstanding limit stops FB after 4; one return releases exactly one more
    do_reset();
    fb_read = 1;
    repeat (6) step();
    check("t3_fb4", dut_fb, 4);
    #1 check("t3_block", fb_waitrequest, 1'b1);
    mem_readdataid = 2'd3;
    step();
    mem_readdataid = 2'd0;
    repeat (4) step();
    check("t3_fb5", dut_fb, 5);
    // lock holds the cpu through stalls even after FB arrives
    do_reset();
    cpu_read = 1; cpu_address = 30'h2a; mem_waitrequest = 1;
    step();
    fb_read = 1; fb_address = 30'h55;
    step();
    step();
    mem_waitrequest = 0;
    step();
    check("t4_cpu", dut_last, 2);
    check("t4_fb0", dut_fb, 0);
    cpu_read = 0;
    step();
    check("t4_fb", dut_last, 1);
    // cpu and aux alternate starting with cpu
    do_reset();
    cpu_write = 1; aux_write = 1; cpu_address = 30'h11; aux_address = 30'h22;
    aux_writedata = 32'hdeadbeef; aux_writedatamask = 4'h5; cpu_writedata = 32'h1234; cpu_writedatamask = 4'hf;
    for (int i = 0; i < 6; i++) begin
      step();
      check("t5_rr", dut_last, (i % 2 == 0) ? 2 : 3);
    end
    // reset mid-lock drops the command immediately, counters restart
    do_reset();
    cpu_read = 1; mem_waitrequest = 1;
    step();
    #1 check("t6_locked", mem_read, 1'b1);
    reset_n = 0;
    #1;
    check("t6_read", mem_read, 1'b0);
    check("t6_waits", {fb_waitrequest, cpu_waitrequest, aux_waitrequest}, 3'b111);
    model_reset();
    @(negedge clock);
    idle_inputs();
    reset_n = 1;
    dut_fb = 0;
    fb_read = 1;
    repeat (5) step();
    check("t6_outst", dut_fb, 4);
    // randomized traffic; a locked master keeps its command stable
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (m_lock != 1) begin
        fb_read = ($urandom_range(0, 99) < 60);
        fb_address = 30'($urandom);
      end
      if (m_lock != 2) begin
        int r = $urandom_range(0, 2);
        cpu_read = (r == 1); cpu_write = (r == 2);
        cpu_id = 2'($urandom_range(1, 2)); cpu_address = 30'($urandom);
        cpu_writedata = $urandom; cpu_writedatamask = 4'($urandom);
      end
      if (m_lock != 3) begin
        aux_write = ($urandom_range(0, 99) < 40);
        aux_address = 30'($urandom); aux_writedata = $urandom; aux_writedatamask = 4'($urandom);
      end
      mem_waitrequest = ($urandom_range(0, 99) < 30);
      mem_readdataid = ($urandom_range(0, 99) < 25) ? 2'd3 : 2'($urandom_range(0, 2));
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
